bp_cacc_vdp_sched: RTL and testbench

BP_CACC_VDP_SCHED -- requirements
Module: bp_cacc_vdp_sched

---
 rtl/bp_cacc_pkg.sv | 70 +++++++
 rtl/bp_cacc_rr_arb.sv | 43 ++++
 rtl/bp_cacc_vdp_sched.sv | 202 ++++++++++++++++++++
 tb/tb_bp_cacc_vdp_sched.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_cacc_pkg.sv
// Shared definitions for the vector dot-product scheduler: accelerator CSR map,
// job descriptor, command word, state encoding and command-sequencing helpers.
package bp_cacc_pkg;

    localparam logic [19:0] csr_a_ptr   = 20'h00000;
    localparam logic [19:0] csr_b_ptr   = 20'h00040;
    localparam logic [19:0] csr_len     = 20'h00080;
    localparam logic [19:0] csr_start   = 20'h000c0;
    localparam logic [19:0] csr_status  = 20'h00100;
    localparam logic [19:0] csr_res_ptr = 20'h00140;

    typedef enum logic [3:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_LEN,
        WR_RES,
        WR_START,
        WAIT_RESP,
        POLL,
        POLL_WAIT,
        POLL_GAP,
        COMPLETE
    } state_e;

    // Pointers are held at full CSR width so any vaddr_width_p up to 64 zero-extends.
    typedef struct packed {
        logic [63:0] a_ptr;
        logic [63:0] b_ptr;
        logic [63:0] res_ptr;
        logic [3:0]  len;
    } desc_t;

    typedef struct packed {
        logic        w;
        logic [19:0] addr;
        logic [63:0] data;
    } cmd_t;

    function automatic cmd_t csr_cmd(input state_e s, input desc_t d);
        cmd_t c;
        c.w    = 1'b1;
        c.addr = '0;
        c.data = '0;
        case (s)
            WR_A:     begin c.addr = csr_a_ptr;   c.data = d.a_ptr;          end
            WR_B:     begin c.addr = csr_b_ptr;   c.data = d.b_ptr;          end
            WR_LEN:   begin c.addr = csr_len;     c.data = {60'd0, d.len};   end
            WR_RES:   begin c.addr = csr_res_ptr; c.data = d.res_ptr;        end
            WR_START: begin c.addr = csr_start;   c.data = 64'd1;            end
            POLL:     begin c.w = 1'b0;           c.addr = csr_status;       end
            default:  c.w = 1'b0;
        endcase
        return c;
    endfunction

    function automatic state_e next_step(input state_e s);
        state_e n;
        case (s)
            WR_A:     n = WR_B;
            WR_B:     n = WR_LEN;
            WR_LEN:   n = WR_RES;
            WR_RES:   n = WR_START;
            WR_START: n = POLL;
            default:  n = IDLE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/bp_cacc_rr_arb.sv
// Round-robin arbiter: one-hot grant starting at a rotating priority pointer,
// pointer moves to the slot after the winner whenever a grant is issued.
module bp_cacc_rr_arb #(
    parameter int num_req_p = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic [num_req_p-1:0]         req,
    output logic [num_req_p-1:0]         grant,
    output logic [$clog2(num_req_p)-1:0] grant_id
);

    localparam int id_w = $clog2(num_req_p);

    logic [id_w-1:0] ptr;
    logic            found;
    int              idx;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < num_req_p; i++) begin
            idx = (int'(ptr) + i) % num_req_p;
            if (!found && en && req[idx]) begin
                found    = 1'b1;
                grant_id = id_w'(idx);
            end
        end
        if (found) grant[grant_id] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= (grant_id == id_w'(num_req_p - 1)) ? '0 : grant_id + id_w'(1);
        end
    end

endmodule

// File: rtl/bp_cacc_vdp_sched.sv
// Dot-product job scheduler: arbitrates requesters, programs the accelerator CSRs,
// polls status and reports completion. Define BP_CACC_VDP_SCHED_TIMEOUT_EN for a poll timeout.
module bp_cacc_vdp_sched
    import bp_cacc_pkg::*;
#(
    parameter int num_req_p     = 2,
    parameter int vaddr_width_p = 39,
    parameter int max_len_p     = 8,
    parameter int poll_gap_p    = 4,
    parameter int timeout_p     = 4096
) (
    input  logic                                       clk_i,
    input  logic                                       reset_n_i,
    input  logic [num_req_p-1:0]                       req_v_i,
    input  logic [num_req_p*(3*vaddr_width_p+4)-1:0]   req_desc_i,
    output logic [num_req_p-1:0]                       req_ready_o,
    output logic                                       acc_cmd_v_o,
    output logic                                       acc_cmd_w_o,
    output logic [19:0]                                acc_cmd_addr_o,
    output logic [63:0]                                acc_cmd_data_o,
    input  logic                                       acc_cmd_ready_i,
    input  logic                                       acc_resp_v_i,
    input  logic [63:0]                                acc_resp_data_i,
    output logic                                       done_v_o,
    output logic [$clog2(num_req_p)-1:0]               done_id_o,
    output logic                                       done_err_o,
    input  logic                                       done_ready_i,
    output logic                                       busy_o,
    output state_e                                     state_o
);

    // Every valid/ready pair transfers on a rising edge where both are high; the
    // side raising valid keeps it and its payload unchanged until that edge.

    localparam int dw    = 3*vaddr_width_p + 4;
    localparam int id_w  = $clog2(num_req_p);
    localparam int gap_w = $clog2(poll_gap_p + 2);

    state_e                state, issued;
    desc_t                 desc, in_desc;
    cmd_t                  cmd_q;
    logic                  busy_seen;
    logic [gap_w-1:0]      gap_cnt;
    logic [num_req_p-1:0]  grant;
    logic [id_w-1:0]       grant_id;
    logic                  arb_en, accept, legal, expired, start_acc;
    logic [dw-1:0]         sel_desc;

    assign arb_en = (state == IDLE) && reset_n_i;

    bp_cacc_rr_arb #(.num_req_p(num_req_p)) u_arb (
        .clk      (clk_i),
        .rst_n    (reset_n_i),
        .en       (arb_en),
        .req      (req_v_i),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign sel_desc    = req_desc_i[grant_id*dw +: dw];

    always_comb begin
        in_desc = '0;
        in_desc.a_ptr[vaddr_width_p-1:0]   = sel_desc[dw-1 -: vaddr_width_p];
        in_desc.b_ptr[vaddr_width_p-1:0]   = sel_desc[2*vaddr_width_p+3 -: vaddr_width_p];
        in_desc.res_ptr[vaddr_width_p-1:0] = sel_desc[vaddr_width_p+3 -: vaddr_width_p];
        in_desc.len                        = sel_desc[3:0];
    end

    assign legal     = (in_desc.len != 4'd0) && (int'(in_desc.len) <= max_len_p);
    assign start_acc = (state == WR_START) && acc_cmd_ready_i;

`ifdef BP_CACC_VDP_SCHED_TIMEOUT_EN
    localparam int tmo_w = $clog2(timeout_p + 1);

    logic             tmo_run;
    logic [tmo_w-1:0] tmo_cnt;

    // Counter saturates at the limit; the FSM acts on it only once no response is owed.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            tmo_run <= 1'b0;
            tmo_cnt <= '0;
        end else if (state == IDLE || state == COMPLETE) begin
            tmo_run <= 1'b0;
            tmo_cnt <= '0;
        end else if (start_acc) begin
            tmo_run <= 1'b1;
            tmo_cnt <= '0;
        end else if (tmo_run && !expired) begin
            tmo_cnt <= tmo_cnt + tmo_w'(1);
        end
    end

    assign expired = tmo_run && (tmo_cnt >= tmo_w'(timeout_p));
`else
    localparam int unused_timeout_p = timeout_p;
    assign expired = 1'b0;
`endif

    assign acc_cmd_w_o    = cmd_q.w;
    assign acc_cmd_addr_o = cmd_q.addr;
    assign acc_cmd_data_o = cmd_q.data;
    assign busy_o         = (state != IDLE);
    assign state_o        = state;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state       <= IDLE;
            issued      <= IDLE;
            desc        <= '0;
            cmd_q       <= '0;
            busy_seen   <= 1'b0;
            gap_cnt     <= '0;
            acc_cmd_v_o <= 1'b0;
            done_v_o    <= 1'b0;
            done_id_o   <= '0;
            done_err_o  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        desc      <= in_desc;
                        done_id_o <= grant_id;
                        if (legal) begin
                            state       <= WR_A;
                            cmd_q       <= csr_cmd(WR_A, in_desc);
                            acc_cmd_v_o <= 1'b1;
                        end else begin
                            state      <= COMPLETE;
                            done_v_o   <= 1'b1;
                            done_err_o <= 1'b1;
                        end
                    end
                end
                WR_A, WR_B, WR_LEN, WR_RES, WR_START, POLL: begin
                    if (acc_cmd_ready_i) begin
                        acc_cmd_v_o <= 1'b0;
                        issued      <= state;
                        state       <= (state == POLL) ? POLL_WAIT : WAIT_RESP;
                    end
                end
                WAIT_RESP: begin
                    if (acc_resp_v_i) begin
                        if (expired) begin
                            state      <= COMPLETE;
                            done_v_o   <= 1'b1;
                            done_err_o <= 1'b1;
                        end else begin
                            state       <= next_step(issued);
                            cmd_q       <= csr_cmd(next_step(issued), desc);
                            acc_cmd_v_o <= 1'b1;
                        end
                    end
                end
                POLL_WAIT: begin
                    if (acc_resp_v_i) begin
                        // A nonzero status only means done once the job was seen running.
                        if (acc_resp_data_i != 64'd0 && busy_seen) begin
                            state      <= COMPLETE;
                            done_v_o   <= 1'b1;
                            done_err_o <= 1'b0;
                        end else if (expired) begin
                            state      <= COMPLETE;
                            done_v_o   <= 1'b1;
                            done_err_o <= 1'b1;
                        end else begin
                            if (acc_resp_data_i == 64'd0) busy_seen <= 1'b1;
                            state   <= POLL_GAP;
                            gap_cnt <= gap_w'(poll_gap_p);
                        end
                    end
                end
                POLL_GAP: begin
                    if (expired) begin
                        state      <= COMPLETE;
                        done_v_o   <= 1'b1;
                        done_err_o <= 1'b1;
                    end else if (gap_cnt <= gap_w'(1)) begin
                        state       <= POLL;
                        cmd_q       <= csr_cmd(POLL, desc);
                        acc_cmd_v_o <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - gap_w'(1);
                    end
                end
                COMPLETE: begin
                    if (done_ready_i) begin
                        state      <= IDLE;
                        done_v_o   <= 1'b0;
                        done_err_o <= 1'b0;
                        busy_seen  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bp_cacc_vdp_sched.sv
// Directed bench for bp_cacc_vdp_sched: CSR sequence, arbitration, illegal lengths,
// back-pressure, completion hold and mid-job reset; timeout steps when the macro is set.
module tb_bp_cacc_vdp_sched;
    import bp_cacc_pkg::*;

    logic          clk;
    logic          reset_n;
    logic [1:0]    req_v;
    logic [241:0]  req_desc;
    logic [1:0]    req_ready;
    logic          cmd_v, cmd_w;
    logic [19:0]   cmd_addr;
    logic [63:0]   cmd_data;
    logic          cmd_ready;
    logic          resp_v;
    logic [63:0]   resp_data;
    logic          done_v;
    logic [0:0]    done_id;
    logic          done_err;
    logic          done_ready;
    logic          busy;
    state_e        dbg_state;

    int total;
    int passed;
    int waited;
    int n;

    bp_cacc_vdp_sched #(
        .num_req_p     (2),
        .vaddr_width_p (39),
        .max_len_p     (8),
        .poll_gap_p    (4),
        .timeout_p     (64)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .req_v_i         (req_v),
        .req_desc_i      (req_desc),
        .req_ready_o     (req_ready),
        .acc_cmd_v_o     (cmd_v),
        .acc_cmd_w_o     (cmd_w),
        .acc_cmd_addr_o  (cmd_addr),
        .acc_cmd_data_o  (cmd_data),
        .acc_cmd_ready_i (cmd_ready),
        .acc_resp_v_i    (resp_v),
        .acc_resp_data_i (resp_data),
        .done_v_o        (done_v),
        .done_id_o       (done_id),
        .done_err_o      (done_err),
        .done_ready_i    (done_ready),
        .busy_o          (busy),
        .state_o         (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [120:0] pack_desc(input logic [38:0] a, input logic [38:0] b,
                                               input logic [38:0] r, input logic [3:0] len);
        return {a, b, r, len};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Entered on a negedge; serves one command with 'stall' cycles of back-pressure.
    task automatic run_cmd(input string tag, input logic [19:0] addr, input logic [63:0] data,
                           input logic w, input int stall, input logic [63:0] resp,
                           output int wcnt);
        wcnt = 0;
        while (!cmd_v && wcnt < 100) begin
            @(negedge clk);
            wcnt++;
        end
        for (int k = 0; k <= stall; k++) begin
            check($sformatf("%s_v%0d", tag, k), 64'(cmd_v), 64'd1);
            check($sformatf("%s_w%0d", tag, k), 64'(cmd_w), 64'(w));
            check($sformatf("%s_addr%0d", tag, k), 64'(cmd_addr), 64'(addr));
            check($sformatf("%s_data%0d", tag, k), cmd_data, data);
            if (k == stall) cmd_ready = 1'b1;
            @(negedge clk);
        end
        cmd_ready = 1'b0;
        check($sformatf("%s_single", tag), 64'(cmd_v), 64'd0);
        resp_v    = 1'b1;
        resp_data = resp;
        @(negedge clk);
        resp_v    = 1'b0;
        resp_data = 64'd0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        total      = 0;
        passed     = 0;
        reset_n    = 1'b0;
        req_v      = 2'b11;
        req_desc   = '0;
        cmd_ready  = 1'b0;
        resp_v     = 1'b0;
        resp_data  = 64'd0;
        done_ready = 1'b0;

        // Reset values, with requests already pending
        repeat (2) @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        check("rst_cmd_v", 64'(cmd_v), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done_v", 64'(done_v), 64'd0);
        check("rst_done_err", 64'(done_err), 64'd0);
        check("rst_cmd_addr", 64'(cmd_addr), 64'd0);
        check("rst_cmd_data", cmd_data, 64'd0);
        check("rst_state", 64'(dbg_state), 64'(IDLE));
        req_v   = 2'b00;
        reset_n = 1'b1;
        @(negedge clk);

        // Basic job on requester 0
        req_desc = {pack_desc(39'h7, 39'h7, 39'h7, 4'd3),
                    pack_desc(39'h1000, 39'h2000, 39'h3000, 4'd4)};
        req_v = 2'b01;
        #1;
        check("j1_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_v    = 2'b00;
        req_desc = {121'h0, {121{1'b1}}};
        check("j1_busy", 64'(busy), 64'd1);
        run_cmd("j1_a", 20'h00000, 64'h1000, 1'b1, 0, 64'd0, waited);
        check("j1_a_lat", 64'(waited), 64'd0);
        run_cmd("j1_b", 20'h00040, 64'h2000, 1'b1, 0, 64'd0, waited);
        check("j1_b_lat", 64'(waited), 64'd0);
        run_cmd("j1_len", 20'h00080, 64'd4, 1'b1, 0, 64'd0, waited);
        run_cmd("j1_res", 20'h00140, 64'h3000, 1'b1, 0, 64'd0, waited);
        run_cmd("j1_start", 20'h000c0, 64'd1, 1'b1, 0, 64'd0, waited);
        run_cmd("j1_p0", 20'h00100, 64'd0, 1'b0, 0, 64'd1, waited);
        check("j1_p0_lat", 64'(waited), 64'd0);
        check("j1_early_done", 64'(done_v), 64'd0);
        run_cmd("j1_p1", 20'h00100, 64'd0, 1'b0, 0, 64'd0, waited);
        check("j1_gap1", 64'(waited), 64'd4);
        check("j1_mid_done", 64'(done_v), 64'd0);
        run_cmd("j1_p2", 20'h00100, 64'd0, 1'b0, 0, 64'd1, waited);
        check("j1_gap2", 64'(waited), 64'd4);
        check("j1_done_v", 64'(done_v), 64'd1);
        check("j1_done_id", 64'(done_id), 64'd0);
        check("j1_done_err", 64'(done_err), 64'd0);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("j1_done_clr", 64'(done_v), 64'd0);
        check("j1_idle", 64'(busy), 64'd0);

        // Alternating grants with illegal lengths (0 on req 0, 9 on req 1)
        do_reset();
        req_desc   = {pack_desc(39'h5, 39'h6, 39'h7, 4'd9), pack_desc(39'h1, 39'h2, 39'h3, 4'd0)};
        req_v      = 2'b11;
        done_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            check($sformatf("rr%0d_grant", j), 64'(req_ready), 64'(1 << (j % 2)));
            @(negedge clk);
            check($sformatf("rr%0d_done_v", j), 64'(done_v), 64'd1);
            check($sformatf("rr%0d_err", j), 64'(done_err), 64'd1);
            check($sformatf("rr%0d_id", j), 64'(done_id), 64'(j % 2));
            check($sformatf("rr%0d_no_cmd", j), 64'(cmd_v), 64'd0);
            check($sformatf("rr%0d_no_ready", j), 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        req_v      = 2'b00;
        done_ready = 1'b0;
        @(negedge clk);

        // Requester 1, max length, stalled LEN write, held completion
        req_desc = {pack_desc(39'hA0, 39'hB0, 39'hC0, 4'd8), pack_desc(39'h1, 39'h2, 39'h3, 4'd1)};
        req_v = 2'b10;
        #1;
        check("j2_ready", 64'(req_ready), 64'd2);
        @(negedge clk);
        req_v    = 2'b00;
        req_desc = '0;
        run_cmd("j2_a", 20'h00000, 64'hA0, 1'b1, 0, 64'd0, waited);
        run_cmd("j2_b", 20'h00040, 64'hB0, 1'b1, 0, 64'd0, waited);
        run_cmd("j2_len", 20'h00080, 64'd8, 1'b1, 5, 64'd0, waited);
        run_cmd("j2_res", 20'h00140, 64'hC0, 1'b1, 0, 64'd0, waited);
        check("j2_res_lat", 64'(waited), 64'd0);
        run_cmd("j2_start", 20'h000c0, 64'd1, 1'b1, 0, 64'd0, waited);
        run_cmd("j2_p0", 20'h00100, 64'd0, 1'b0, 0, 64'd0, waited);
        run_cmd("j2_p1", 20'h00100, 64'd0, 1'b0, 0, 64'd2, waited);
        check("j2_gap", 64'(waited), 64'd4);
        req_v = 2'b11;
        for (int j = 0; j < 10; j++) begin
            check($sformatf("hold%0d_done_v", j), 64'(done_v), 64'd1);
            check($sformatf("hold%0d_id", j), 64'(done_id), 64'd1);
            check($sformatf("hold%0d_err", j), 64'(done_err), 64'd0);
            check($sformatf("hold%0d_ready", j), 64'(req_ready), 64'd0);
            @(negedge clk);
        end
        req_v      = 2'b00;
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("j2_done_clr", 64'(done_v), 64'd0);
        check("j2_idle", 64'(busy), 64'd0);

        // Reset while polling abandons the job
        req_desc = {pack_desc(39'h0, 39'h0, 39'h0, 4'd0), pack_desc(39'h11, 39'h22, 39'h33, 4'd1)};
        req_v = 2'b01;
        #1;
        check("j3_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_v = 2'b00;
        run_cmd("j3_a", 20'h00000, 64'h11, 1'b1, 0, 64'd0, waited);
        run_cmd("j3_b", 20'h00040, 64'h22, 1'b1, 0, 64'd0, waited);
        run_cmd("j3_len", 20'h00080, 64'd1, 1'b1, 0, 64'd0, waited);
        run_cmd("j3_res", 20'h00140, 64'h33, 1'b1, 0, 64'd0, waited);
        run_cmd("j3_start", 20'h000c0, 64'd1, 1'b1, 0, 64'd0, waited);
        check("j3_poll_v", 64'(cmd_v), 64'd1);
        check("j3_poll_addr", 64'(cmd_addr), 64'h100);
        check("j3_poll_state", 64'(dbg_state), 64'(POLL));
        reset_n = 1'b0;
        #1;
        check("j3_rst_state", 64'(dbg_state), 64'(IDLE));
        check("j3_rst_busy", 64'(busy), 64'd0);
        check("j3_rst_cmd_v", 64'(cmd_v), 64'd0);
        check("j3_rst_done_v", 64'(done_v), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check($sformatf("j3_after%0d_done", j), 64'(done_v), 64'd0);
            check($sformatf("j3_after%0d_cmd", j), 64'(cmd_v), 64'd0);
        end

`ifdef BP_CACC_VDP_SCHED_TIMEOUT_EN
        // Status never goes done: the poll timeout must end the job with an error
        req_desc = {pack_desc(39'h0, 39'h0, 39'h0, 4'd0), pack_desc(39'h44, 39'h55, 39'h66, 4'd2)};
        req_v = 2'b01;
        #1;
        check("tmo_ready", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_v = 2'b00;
        run_cmd("tmo_a", 20'h00000, 64'h44, 1'b1, 0, 64'd0, waited);
        run_cmd("tmo_b", 20'h00040, 64'h55, 1'b1, 0, 64'd0, waited);
        run_cmd("tmo_len", 20'h00080, 64'd2, 1'b1, 0, 64'd0, waited);
        run_cmd("tmo_res", 20'h00140, 64'h66, 1'b1, 0, 64'd0, waited);
        run_cmd("tmo_start", 20'h000c0, 64'd1, 1'b1, 0, 64'd0, waited);
        n = 0;
        resp_data = 64'd0;
        while (!done_v && n < 300) begin
            if (cmd_ready) begin
                cmd_ready = 1'b0;
                resp_v    = 1'b1;
            end else begin
                resp_v    = 1'b0;
                cmd_ready = cmd_v;
            end
            @(negedge clk);
            n++;
        end
        cmd_ready = 1'b0;
        resp_v    = 1'b0;
        check("tmo_done_v", 64'(done_v), 64'd1);
        check("tmo_err", 64'(done_err), 64'd1);
        check("tmo_id", 64'(done_id), 64'd0);
        check("tmo_window", 64'(n >= 55 && n <= 85), 64'd1);
        done_ready = 1'b1;
        @(negedge clk);
        done_ready = 1'b0;
        check("tmo_idle", 64'(busy), 64'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
